fir_tap_seq_ctrl: RTL and testbench
===================================

Name: fir_tap_seq_ctrl

Overview:
Parametrised controller for the transposed-form FIR datapath. It steers host coefficient writes into the coefficient SpSram and range-checks them. It then sweeps the SRAM once to load the per-tap coefficient registers, and sequences sample acceptance through the multiply/accumulate pipeline with a valid/ready handshake. It sits between the host bus, the SpSram, and the tap datapath, and replaces the fixed 4-state controller with a tap-count-generic, pipelined, back-pressured version.

Parameters:
P_COEFF_W, 16, coefficient width in bits
P_ADDR_W, 6, SRAM address width; iNumOfCoeff width
P_MAX_TAP, 33, largest legal tap count (must be <= 2**P_ADDR_W)
P_MUL_LAT, 2, multiplier pipeline depth in cycles

Ports:
iClk_12M  in  1  clock
iRsn  in  1  asynchronous active-low reset
iCoeffiUpdateFlag  in  1  host request to (re)load coefficients, level
iCsnRam  in  1  host chip select, active-low
iWrnRam  in  1  host write strobe, active-low
iAddrRam  in  P_ADDR_W  host coefficient address
iWrDtRam  in  P_COEFF_W  host coefficient data, signed
iNumOfCoeff  in  P_ADDR_W  active tap count N
iInValid  in  1  input sample valid
oInReady  out  1  controller accepts a sample this cycle
oCsnRam  out  1  SRAM chip select, active-low, registered
oWrnRam  out  1  SRAM write strobe, active-low, registered
oAddrRam  out  P_ADDR_W  SRAM address, registered
oWrDtRam  out  P_COEFF_W  SRAM write data, registered
oCoeffLd  out  1  load SRAM read data into tap register oCoeffIdx
oCoeffIdx  out  P_ADDR_W  tap register index
oEnDelay  out  1  shift/advance transposed delay chain
oEnAcc  out  1  enable adder/accumulator stage
oOutValid  out  1  filter output valid
oBusy  out  1  high in every state except RUN
oErr  out  1  sticky error flag; cleared by reset or next IDLE->LOAD

Behaviour:
- Reset (asynchronous, iRsn=0):
  - State goes to IDLE and all counters and pipeline bits clear.
  - Outputs: oCsnRam=1, oWrnRam=1, oAddrRam=0, oWrDtRam=0, oCoeffLd=0, oCoeffIdx=0, oEnDelay=0, oEnAcc=0, oOutValid=0, oInReady=0, oBusy=1, oErr=0.
  - Reset mid-write or mid-sweep aborts immediately; no partial recovery.
- States: IDLE, LOAD, FETCH, DRAIN, RUN, FLUSH.
- IDLE:
  - SRAM outputs are idle.
  - Goes to LOAD when iCoeffiUpdateFlag=1; oErr clears on this transition.
- LOAD:
  - When iCsnRam=0 and iWrnRam=0 and iAddrRam < iNumOfCoeff, the write is forwarded next cycle: oCsnRam=0, oWrnRam=0, oAddrRam=iAddrRam, oWrDtRam=iWrDtRam, for exactly one cycle.
  - An out-of-range write is dropped and sets oErr.
  - Host reads (iWrnRam=1) are ignored.
  - Leaves when iCoeffiUpdateFlag=0. N is latched at that edge.
  - If N=0 or N>P_MAX_TAP: oErr=1 and next state is IDLE. Otherwise next state is FETCH.
- FETCH:
  - Counter k runs 0..N-1, one per cycle.
  - Registered outputs oCsnRam=0, oWrnRam=1, oAddrRam=k.
  - SRAM read latency is 1, so oCoeffLd=1 with oCoeffIdx=k appears two cycles after k is issued (output register plus SRAM).
  - After issuing k=N-1, go to DRAIN.
- DRAIN:
  - oCsnRam=1. Waits until the final oCoeffLd (idx N-1) has been emitted, then goes to RUN.
  - First RUN cycle is exactly N+2 cycles after FETCH entry.
- RUN:
  - oInReady = ~iCoeffiUpdateFlag (combinational).
  - A sample is accepted when iInValid & oInReady; oEnDelay = accept (same cycle).
  - oEnAcc = accept delayed P_MUL_LAT cycles; oOutValid = accept delayed P_MUL_LAT+1 cycles (shift register, one bit per stage).
  - Back-to-back accepts are allowed every cycle.
  - iCoeffiUpdateFlag=1 goes to FLUSH. A sample presented in the same cycle is not accepted (update wins).
- FLUSH:
  - oInReady=0 and oEnDelay=0; the pipeline shift register continues.
  - When all P_MUL_LAT+1 pipeline bits are 0, go to LOAD. Pending oEnAcc/oOutValid pulses always complete.
- oInReady=0 and oEnDelay=0 in every state except RUN.
- Counter k wraps never; its range is bounded by N <= P_MAX_TAP.

Test Plan:
- Reset, flag=1, write addr 0..4 with data 16'h0100+addr, N=5, drop flag -> five SRAM writes each 1 cycle late. FETCH issues addresses 0..4; oCoeffLd idx 0..4 appears on consecutive cycles; RUN is entered at cycle N+2=7 after FETCH entry.
- In LOAD with N=5, write to addr 7 -> no SRAM write, oErr=1, sequencing continues to RUN.
- N=0 at flag drop -> return to IDLE with oErr=1; N=40 with P_MAX_TAP=33 -> same.
- RUN, iInValid=1 for 4 consecutive cycles -> 4 oEnDelay pulses, oEnAcc at +2, oOutValid at +3 (P_MUL_LAT=2), contiguous.
- RUN, assert iCoeffiUpdateFlag together with iInValid on the cycle after 2 accepts -> that sample is not accepted. The 2 pending oOutValid pulses still occur, then the state enters LOAD; oBusy=1 from the FLUSH entry onward.
- Assert iRsn=0 mid-FETCH (k=3) -> all outputs take reset values asynchronously; after release, state is IDLE with no oCoeffLd.

Source files
------------

// File: rtl/fir_tap_seq_ctrl_if.sv
// Host, SRAM, handshake and tap-datapath signals of the FIR tap sequencer.
// The master side drives the host/sample inputs; the slave side is the controller.
interface fir_tap_seq_ctrl_if #(
  parameter int P_COEFF_W = 16,
  parameter int P_ADDR_W  = 6
);
  logic                 iCoeffiUpdateFlag;
  logic                 iCsnRam;
  logic                 iWrnRam;
  logic [P_ADDR_W-1:0]  iAddrRam;
  logic [P_COEFF_W-1:0] iWrDtRam;
  logic [P_ADDR_W-1:0]  iNumOfCoeff;
  logic                 iInValid;
  logic                 oInReady;
  logic                 oCsnRam;
  logic                 oWrnRam;
  logic [P_ADDR_W-1:0]  oAddrRam;
  logic [P_COEFF_W-1:0] oWrDtRam;
  logic                 oCoeffLd;
  logic [P_ADDR_W-1:0]  oCoeffIdx;
  logic                 oEnDelay;
  logic                 oEnAcc;
  logic                 oOutValid;
  logic                 oBusy;
  logic                 oErr;

  modport master (
    output iCoeffiUpdateFlag, iCsnRam, iWrnRam, iAddrRam, iWrDtRam, iNumOfCoeff, iInValid,
    input  oInReady, oCsnRam, oWrnRam, oAddrRam, oWrDtRam, oCoeffLd, oCoeffIdx,
           oEnDelay, oEnAcc, oOutValid, oBusy, oErr
  );

  modport slave (
    input  iCoeffiUpdateFlag, iCsnRam, iWrnRam, iAddrRam, iWrDtRam, iNumOfCoeff, iInValid,
    output oInReady, oCsnRam, oWrnRam, oAddrRam, oWrDtRam, oCoeffLd, oCoeffIdx,
           oEnDelay, oEnAcc, oOutValid, oBusy, oErr
  );
endinterface

// File: rtl/fir_tap_seq_ctrl.sv
// Tap-count-generic FIR controller: coefficient write steering, SRAM sweep into
// tap registers, and back-pressured sample sequencing through the MAC pipeline.
module fir_tap_seq_ctrl #(
  parameter int P_COEFF_W = 16,
  parameter int P_ADDR_W  = 6,
  parameter int P_MAX_TAP = 33,
  parameter int P_MUL_LAT = 2
) (
  input logic               iClk_12M,
  input logic               iRsn,
  fir_tap_seq_ctrl_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    FETCH = 3'd2,
    DRAIN = 3'd3,
    RUN   = 3'd4,
    FLUSH = 3'd5
  } state_t;

  localparam logic [P_ADDR_W-1:0] addr_one_c = P_ADDR_W'(1);
  // One extra bit so P_MAX_TAP == 2**P_ADDR_W is still representable
  localparam logic [P_ADDR_W:0]   max_tap_c  = (P_ADDR_W+1)'(P_MAX_TAP);

  state_t               state_r;
  logic [P_ADDR_W-1:0]  n_r;
  logic [P_ADDR_W-1:0]  k_r;
  logic [P_ADDR_W-1:0]  addr_r;
  logic [P_COEFF_W-1:0] wr_dt_r;
  logic [P_ADDR_W-1:0]  coeff_idx_r;
  logic                 csn_r;
  logic                 wrn_r;
  logic                 rd_pend_r;
  logic                 coeff_ld_r;
  logic                 err_r;
  logic                 busy_r;
  logic [P_MUL_LAT:0]   pipe_r;
  logic                 ready_s;
  logic                 accept_s;
  logic                 wr_req_s;
  logic                 n_bad_s;

  // Ready is combinational so a pending update blocks the sample in the same cycle
  always_comb begin
    ready_s = 1'b0;
    if (state_r == RUN) begin
      ready_s = ~bus.iCoeffiUpdateFlag;
    end else begin
      ready_s = 1'b0;
    end
  end

  assign accept_s = ready_s & bus.iInValid;
  assign wr_req_s = ~bus.iCsnRam & ~bus.iWrnRam;
  assign n_bad_s  = (bus.iNumOfCoeff == '0) || ({1'b0, bus.iNumOfCoeff} > max_tap_c);

  assign bus.oInReady  = ready_s;
  assign bus.oEnDelay  = accept_s;
  assign bus.oCsnRam   = csn_r;
  assign bus.oWrnRam   = wrn_r;
  assign bus.oAddrRam  = addr_r;
  assign bus.oWrDtRam  = wr_dt_r;
  assign bus.oCoeffLd  = coeff_ld_r;
  assign bus.oCoeffIdx = coeff_idx_r;
  assign bus.oEnAcc    = pipe_r[P_MUL_LAT-1];
  assign bus.oOutValid = pipe_r[P_MUL_LAT];
  assign bus.oBusy     = busy_r;
  assign bus.oErr      = err_r;

  // Sequencer state, SRAM port registers, tap-load strobe and MAC valid pipeline
  always_ff @(posedge iClk_12M or negedge iRsn) begin
    if (!iRsn) begin
      state_r     <= IDLE;
      n_r         <= '0;
      k_r         <= '0;
      addr_r      <= '0;
      wr_dt_r     <= '0;
      coeff_idx_r <= '0;
      csn_r       <= 1'b1;
      wrn_r       <= 1'b1;
      rd_pend_r   <= 1'b0;
      coeff_ld_r  <= 1'b0;
      err_r       <= 1'b0;
      busy_r      <= 1'b1;
      pipe_r      <= '0;
    end else begin
      pipe_r     <= {pipe_r[P_MUL_LAT-1:0], accept_s};
      csn_r      <= 1'b1;
      wrn_r      <= 1'b1;
      rd_pend_r  <= 1'b0;
      // SRAM data lands one cycle after the address register, with the tap index
      coeff_ld_r <= rd_pend_r;
      if (rd_pend_r) begin
        coeff_idx_r <= addr_r;
      end
      case (state_r)
        IDLE: begin
          if (bus.iCoeffiUpdateFlag) begin
            state_r <= LOAD;
            err_r   <= 1'b0;
          end
        end
        LOAD: begin
          if (wr_req_s) begin
            if (bus.iAddrRam < bus.iNumOfCoeff) begin
              csn_r   <= 1'b0;
              wrn_r   <= 1'b0;
              addr_r  <= bus.iAddrRam;
              wr_dt_r <= bus.iWrDtRam;
            end else begin
              err_r <= 1'b1;
            end
          end
          if (!bus.iCoeffiUpdateFlag) begin
            n_r <= bus.iNumOfCoeff;
            k_r <= '0;
            if (n_bad_s) begin
              err_r   <= 1'b1;
              state_r <= IDLE;
            end else begin
              state_r <= FETCH;
            end
          end
        end
        FETCH: begin
          csn_r     <= 1'b0;
          addr_r    <= k_r;
          rd_pend_r <= 1'b1;
          if (k_r == n_r - addr_one_c) begin
            state_r <= DRAIN;
          end else begin
            k_r <= k_r + addr_one_c;
          end
        end
        DRAIN: begin
          if (coeff_ld_r && (coeff_idx_r == n_r - addr_one_c)) begin
            state_r <= RUN;
            busy_r  <= 1'b0;
          end
        end
        RUN: begin
          if (bus.iCoeffiUpdateFlag) begin
            state_r <= FLUSH;
            busy_r  <= 1'b1;
          end
        end
        FLUSH: begin
          if (pipe_r == '0) begin
            state_r <= LOAD;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fir_tap_seq_ctrl.sv
// Self-checking bench for fir_tap_seq_ctrl with a behavioural SRAM and
// cycle-indexed expectations derived from the controller's timing rules.
module tb_fir_tap_seq_ctrl;
  localparam int CW   = 16;
  localparam int AW   = 6;
  localparam int MAXT = 33;
  localparam int LAT  = 2;
  localparam int OW   = 2 + AW + CW + 1 + AW + 6;
  localparam logic [OW-1:0] RST_OUTS = {1'b1, 1'b1, AW'(0), CW'(0), 1'b0, AW'(0),
                                        1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  logic exp_err = 1'b0;
  logic [CW-1:0] exp_mem [0:63];
  logic [CW-1:0] sram [0:63];
  logic [CW-1:0] rd_q;

  always #5 clk = ~clk;

  fir_tap_seq_ctrl_if #(.P_COEFF_W(CW), .P_ADDR_W(AW)) bus ();

  fir_tap_seq_ctrl #(.P_COEFF_W(CW), .P_ADDR_W(AW), .P_MAX_TAP(MAXT), .P_MUL_LAT(LAT)) dut (
    .iClk_12M (clk),
    .iRsn     (rst_n),
    .bus      (bus)
  );

  // Behavioural single-port SRAM with one-cycle read latency
  always @(posedge clk) begin
    if (!bus.oCsnRam) begin
      if (!bus.oWrnRam) sram[bus.oAddrRam] <= bus.oWrDtRam;
      else rd_q <= sram[bus.oAddrRam];
    end
  end

  function automatic logic [OW-1:0] outs();
    return {bus.oCsnRam, bus.oWrnRam, bus.oAddrRam, bus.oWrDtRam, bus.oCoeffLd, bus.oCoeffIdx,
            bus.oEnDelay, bus.oEnAcc, bus.oOutValid, bus.oInReady, bus.oBusy, bus.oErr};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (outs() !== RST_OUTS) begin bad++; $display("FAIL reset_vals got=%h want=%h", outs(), RST_OUTS); end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (outs() !== RST_OUTS) begin bad++; $display("FAIL idle_vals got=%h want=%h", outs(), RST_OUTS); end
    end
  endtask

  task automatic test_load_fetch(input int n, input bit fixed_data, input int bad_addr);
    logic [CW-1:0] d;
    logic exp_ld;
    logic exp_csn;
    logic exp_busy;
    bus.iNumOfCoeff = AW'(n);
    bus.iCoeffiUpdateFlag = 1'b1;
    step();
    exp_err = 1'b0;
    total++;
    if (bus.oErr !== exp_err) begin bad++; $display("FAIL load_err_clr got=%b want=%b", bus.oErr, exp_err); end
    for (int a = 0; a < n; a++) begin
      d = fixed_data ? CW'(16'h0100 + a) : CW'($urandom);
      bus.iCsnRam = 1'b0; bus.iWrnRam = 1'b0; bus.iAddrRam = AW'(a); bus.iWrDtRam = d;
      exp_mem[a] = d;
      step();
      bus.iCsnRam = 1'b1; bus.iWrnRam = 1'b1;
      total++;
      if ({bus.oCsnRam, bus.oWrnRam, bus.oAddrRam, bus.oWrDtRam} !== {1'b0, 1'b0, AW'(a), d}) begin
        bad++; $display("FAIL wr_fwd a=%0d got=%b%b/%h/%h want=00/%h/%h", a, bus.oCsnRam, bus.oWrnRam,
                        bus.oAddrRam, bus.oWrDtRam, AW'(a), d);
      end
      step();
      total++;
      if (bus.oCsnRam !== 1'b1) begin bad++; $display("FAIL wr_one_cycle got=%b want=1", bus.oCsnRam); end
    end
    if (bad_addr >= 0) begin
      bus.iCsnRam = 1'b0; bus.iWrnRam = 1'b0; bus.iAddrRam = AW'(bad_addr); bus.iWrDtRam = CW'(16'hBAD0);
      step();
      bus.iCsnRam = 1'b1; bus.iWrnRam = 1'b1;
      exp_err = 1'b1;
      total++;
      if ({bus.oCsnRam, bus.oErr} !== 2'b11) begin
        bad++; $display("FAIL wr_out_of_range got csn,err=%b%b want=11", bus.oCsnRam, bus.oErr);
      end
    end
    bus.iCsnRam = 1'b0; bus.iWrnRam = 1'b1; bus.iAddrRam = AW'(0);
    step();
    bus.iCsnRam = 1'b1;
    total++;
    if (bus.oCsnRam !== 1'b1) begin bad++; $display("FAIL host_read_ignored got=%b want=1", bus.oCsnRam); end
    bus.iCoeffiUpdateFlag = 1'b0;
    step();
    // t counts cycles from FETCH entry; RUN must start at t = n+2
    for (int t = 0; t <= n + 2; t++) begin
      exp_ld   = (t >= 2) && (t <= n + 1);
      exp_csn  = !((t >= 1) && (t <= n));
      exp_busy = (t < n + 2);
      total++;
      if ({bus.oCoeffLd, bus.oCsnRam, bus.oBusy, bus.oErr} !== {exp_ld, exp_csn, exp_busy, exp_err}) begin
        bad++; $display("FAIL sweep t=%0d ld,csn,busy,err got=%b%b%b%b want=%b%b%b%b", t, bus.oCoeffLd,
                        bus.oCsnRam, bus.oBusy, bus.oErr, exp_ld, exp_csn, exp_busy, exp_err);
      end
      if (exp_ld) begin
        total++;
        if ({bus.oCoeffIdx, rd_q} !== {AW'(t - 2), exp_mem[t-2]}) begin
          bad++; $display("FAIL coeff_ld t=%0d got idx=%0d data=%h want idx=%0d data=%h", t, bus.oCoeffIdx,
                          rd_q, t - 2, exp_mem[t-2]);
        end
      end
      if (!exp_csn) begin
        total++;
        if ({bus.oWrnRam, bus.oAddrRam} !== {1'b1, AW'(t - 1)}) begin
          bad++; $display("FAIL fetch_addr t=%0d got wrn=%b addr=%0d want wrn=1 addr=%0d", t, bus.oWrnRam,
                          bus.oAddrRam, t - 1);
        end
      end
      if (t < n + 2) step();
    end
  endtask

  task automatic test_run_stream(input int n_cyc, input bit burst);
    logic acc [0:127];
    logic v;
    logic exp_ea;
    logic exp_ov;
    for (int c = 0; c < n_cyc + LAT + 2; c++) begin
      v = (c < n_cyc) ? (burst ? 1'b1 : 1'($urandom_range(0, 1))) : 1'b0;
      acc[c] = v;
      exp_ea = (c >= LAT) ? acc[c-LAT] : 1'b0;
      exp_ov = (c >= LAT + 1) ? acc[c-LAT-1] : 1'b0;
      total++;
      if ({bus.oEnAcc, bus.oOutValid, bus.oBusy} !== {exp_ea, exp_ov, 1'b0}) begin
        bad++; $display("FAIL run_pipe c=%0d acc,ov,busy got=%b%b%b want=%b%b0", c, bus.oEnAcc,
                        bus.oOutValid, bus.oBusy, exp_ea, exp_ov);
      end
      bus.iInValid = v;
      #1;
      total++;
      if ({bus.oInReady, bus.oEnDelay} !== {1'b1, v}) begin
        bad++; $display("FAIL run_accept c=%0d rdy,en got=%b%b want=1%b", c, bus.oInReady, bus.oEnDelay, v);
      end
      step();
    end
    bus.iInValid = 1'b0;
  endtask

  task automatic test_flush();
    logic exp_ea;
    logic exp_ov;
    logic [CW-1:0] d_keep;
    d_keep = CW'($urandom);
    // Two accepts at c=0,1; update with a valid sample at c=2; LOAD expected at c=LAT+4
    for (int c = 0; c <= LAT + 4; c++) begin
      exp_ea = (c >= LAT) && (c - LAT < 2);
      exp_ov = (c >= LAT + 1) && (c - LAT - 1 < 2);
      total++;
      if ({bus.oEnAcc, bus.oOutValid, bus.oBusy, bus.oCsnRam} !== {exp_ea, exp_ov, 1'(c >= 3), 1'b1}) begin
        bad++; $display("FAIL flush_pipe c=%0d acc,ov,busy,csn got=%b%b%b%b want=%b%b%b1", c, bus.oEnAcc,
                        bus.oOutValid, bus.oBusy, bus.oCsnRam, exp_ea, exp_ov, 1'(c >= 3));
      end
      bus.iInValid = 1'b1;
      bus.iCoeffiUpdateFlag = (c >= 2);
      bus.iCsnRam = 1'b1; bus.iWrnRam = 1'b1; bus.iAddrRam = AW'(0);
      if (c == LAT + 3) begin
        bus.iCsnRam = 1'b0; bus.iWrnRam = 1'b0; bus.iWrDtRam = ~d_keep;
      end
      if (c == LAT + 4) begin
        bus.iCsnRam = 1'b0; bus.iWrnRam = 1'b0; bus.iWrDtRam = d_keep;
        exp_mem[0] = d_keep;
      end
      #1;
      total++;
      if ({bus.oInReady, bus.oEnDelay} !== {1'(c < 2), 1'(c < 2)}) begin
        bad++; $display("FAIL flush_accept c=%0d rdy,en got=%b%b want=%b%b", c, bus.oInReady, bus.oEnDelay,
                        1'(c < 2), 1'(c < 2));
      end
      step();
    end
    bus.iInValid = 1'b0; bus.iCsnRam = 1'b1; bus.iWrnRam = 1'b1;
    total++;
    if ({bus.oCsnRam, bus.oWrnRam, bus.oAddrRam, bus.oWrDtRam, bus.oErr} !== {1'b0, 1'b0, AW'(0), d_keep, exp_err}) begin
      bad++; $display("FAIL flush_to_load got csn=%b addr=%0d data=%h err=%b want csn=0 addr=0 data=%h err=%b",
                      bus.oCsnRam, bus.oAddrRam, bus.oWrDtRam, bus.oErr, d_keep, exp_err);
    end
    bus.iCoeffiUpdateFlag = 1'b0; bus.iNumOfCoeff = AW'(0);
    step();
    exp_err = 1'b1;
    total++;
    if ({bus.oErr, bus.oBusy} !== 2'b11) begin bad++; $display("FAIL flush_n0 err,busy got=%b%b want=11", bus.oErr, bus.oBusy); end
  endtask

  task automatic test_bad_n(input int n);
    bus.iCoeffiUpdateFlag = 1'b1;
    step();
    exp_err = 1'b0;
    total++;
    if (bus.oErr !== 1'b0) begin bad++; $display("FAIL badn_err_clr n=%0d got=%b want=0", n, bus.oErr); end
    bus.iCoeffiUpdateFlag = 1'b0; bus.iNumOfCoeff = AW'(n);
    step();
    exp_err = 1'b1;
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({bus.oCsnRam, bus.oCoeffLd, bus.oBusy, bus.oErr} !== 4'b1011) begin
        bad++; $display("FAIL badn_idle n=%0d i=%0d csn,ld,busy,err got=%b%b%b%b want=1011", n, i,
                        bus.oCsnRam, bus.oCoeffLd, bus.oBusy, bus.oErr);
      end
      step();
    end
  endtask

  task automatic test_reset_mid_fetch(input int n);
    logic [CW-1:0] d;
    bus.iNumOfCoeff = AW'(n);
    bus.iCoeffiUpdateFlag = 1'b1;
    step();
    for (int a = 0; a < n; a++) begin
      d = CW'($urandom);
      bus.iCsnRam = 1'b0; bus.iWrnRam = 1'b0; bus.iAddrRam = AW'(a); bus.iWrDtRam = d;
      step();
      total++;
      if ({bus.oCsnRam, bus.oAddrRam, bus.oWrDtRam} !== {1'b0, AW'(a), d}) begin
        bad++; $display("FAIL b2b_wr a=%0d got csn=%b addr=%0d data=%h want 0/%0d/%h", a, bus.oCsnRam,
                        bus.oAddrRam, bus.oWrDtRam, a, d);
      end
    end
    bus.iCsnRam = 1'b1; bus.iWrnRam = 1'b1; bus.iCoeffiUpdateFlag = 1'b0;
    step();
    repeat (3) step();
    total++;
    if ({bus.oCsnRam, bus.oAddrRam} !== {1'b0, AW'(2)}) begin
      bad++; $display("FAIL mid_fetch got csn=%b addr=%0d want csn=0 addr=2", bus.oCsnRam, bus.oAddrRam);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (outs() !== RST_OUTS) begin bad++; $display("FAIL async_reset got=%h want=%h", outs(), RST_OUTS); end
    step();
    rst_n = 1'b1;
    exp_err = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      total++;
      if ({bus.oCoeffLd, bus.oCsnRam, bus.oBusy, bus.oErr} !== 4'b0110) begin
        bad++; $display("FAIL post_reset i=%0d ld,csn,busy,err got=%b%b%b%b want=0110", i, bus.oCoeffLd,
                        bus.oCsnRam, bus.oBusy, bus.oErr);
      end
    end
  endtask

  initial begin
    bus.iCoeffiUpdateFlag = 1'b0;
    bus.iCsnRam = 1'b1;
    bus.iWrnRam = 1'b1;
    bus.iAddrRam = '0;
    bus.iWrDtRam = '0;
    bus.iNumOfCoeff = '0;
    bus.iInValid = 1'b0;
    test_reset();
    test_load_fetch(5, 1'b1, 7);
    test_run_stream(4, 1'b1);
    test_flush();
    test_bad_n(0);
    test_bad_n(40);
    test_bad_n($urandom_range(MAXT + 1, 63));
    test_load_fetch(MAXT, 1'b0, -1);
    test_run_stream(40, 1'b0);
    test_flush();
    test_load_fetch(1, 1'b0, -1);
    test_run_stream(20, 1'b0);
    test_flush();
    test_load_fetch($urandom_range(2, MAXT), 1'b0, MAXT + 3);
    test_run_stream(30, 1'b0);
    test_flush();
    test_reset_mid_fetch($urandom_range(5, 12));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
